// File: rtl/arith_pkg.sv
// arith_pkg
//   Shared types and sizing helpers for the bit-serial arithmetic blocks.
//   - fsm_state_e : IDLE / RUN / DONE controller states
//   - cnt_width() : bit-counter width for a given operand width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  localparam int unsigned WIDTH_DEFAULT = 4;

  // $clog2(WIDTH), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/one_bit_full_subtractor.sv
// one_bit_full_subtractor
//   Gate-level one-bit full subtractor: a - b - bin.
//   Ports:
//     a, b, bin : minuend bit, subtrahend bit, borrow in
//     d         : difference bit
//     bout      : borrow out
module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor
//   Bit-serial D = A - B - Bin, one bit per clock, LSB first, behind a
//   start/done handshake. A single one-bit cell is reused every cycle.
//   Ports:
//     clk, rst_n   : clock, async active-low reset
//     start        : request, sampled only in IDLE
//     A, B, Bin    : operands, captured when start is accepted
//     busy         : high while in RUN
//     done         : one-cycle pulse, result valid
//     D, Bout, V   : registered difference, unsigned borrow, signed overflow
//
//   state | meaning
//   IDLE  | waiting for start; results hold
//   RUN   | one bit processed per clock
//   DONE  | one-cycle result-valid pulse
module serial_full_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CNT_W = cnt_width(WIDTH);

  fsm_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, v_q;

  logic             cell_d, cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] diff_d;

  one_bit_full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign diff_d   = {cell_d, diff_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_sr_q <= A;
        b_sr_q <= B;
        br_q   <= Bin;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
        br_q   <= cell_bout;
        cnt_q  <= cnt_q + CNT_W'(1);
        diff_q <= diff_d;
        if (last_bit) begin
          d_q    <= diff_d;
          bout_q <= cell_bout;
          // Borrow into the MSB differing from borrow out means the
          // signed result left the representable range.
          v_q    <= br_q ^ cell_bout;
        end
      end
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
module tb_serial_full_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, v;
  logic [W-1:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (d),
    .Bout  (bout),
    .V     (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int unsigned av, input int unsigned bv, input int unsigned bi,
                       output int unsigned dv, output int unsigned bo, output int unsigned ov);
    longint diff, sa, sb, sd, half, full;
    full = longint'(1) << W;
    half = longint'(1) << (W - 1);
    diff = longint'(av) - longint'(bv) - longint'(bi);
    dv   = int'(((diff % full) + full) % full);
    bo   = (diff < 0) ? 1 : 0;
    sa   = (longint'(av) >= half) ? longint'(av) - full : longint'(av);
    sb   = (longint'(bv) >= half) ? longint'(bv) - full : longint'(bv);
    sd   = sa - sb - longint'(bi);
    ov   = (sd < -half || sd > half - 1) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int unsigned av, input int unsigned bv,
                              input int unsigned bi);
    int unsigned dv, bo, ov;
    model(av, bv, bi, dv, bo, ov);
    check({tag, ".D"},    32'(d),    dv);
    check({tag, ".Bout"}, 32'(bout), bo);
    check({tag, ".V"},    32'(v),    ov);
  endtask

  // Full op with exact cycle-by-cycle handshake checking.
  task automatic do_op(input string tag, input int unsigned av, input int unsigned bv,
                       input int unsigned bi);
    a = W'(av); b = W'(bv); bin = bi[0]; start = 1'b1;
    tick();                                   // accept edge
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check({tag, ".busy0"}, 32'(busy), 1);
    for (int k = 1; k < W; k++) begin
      tick();
      check({tag, ".busy"}, 32'(busy), 1);
      check({tag, ".nodone"}, 32'(done), 0);
    end
    tick();
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".busy_end"}, 32'(busy), 0);
    check_result(tag, av, bv, bi);
    tick();
    check({tag, ".done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int cyc;
    logic seen;

    #1;
    check("rst0.busy", 32'(busy), 0);
    check("rst0.done", 32'(done), 0);
    check("rst0.D",    32'(d),    0);
    #20 rst_n = 1'b1;
    tick();

    do_op("op_9_3", 9, 3, 0);
    do_op("op_3_9", 3, 9, 0);
    do_op("op_8_1", 8, 1, 0);
    do_op("op_0_0_b", 0, 0, 1);

    for (int i = 0; i < 10; i++) tick();
    check("hold.done", 32'(done), 0);
    check_result("hold", 0, 0, 1);

    // Start held high while operands churn during RUN.
    a = 4'd2; b = 4'd1; bin = 1'b0; start = 1'b1;
    tick();
    for (int k = 1; k < W; k++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      tick();
    end
    a = 4'd7; b = 4'd4; bin = 1'b0;           // second op, held from here on
    tick();
    check("held.done1", 32'(done), 1);
    check_result("held1", 2, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (busy) seen = 1'b1;
      else check("held.gap_nodone", 32'(done), 0);
    end
    check("held.accept2", 32'(seen), 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      tick();
      cyc++;
    end
    check("held.latency2", 32'(cyc), W);
    check_result("held2", 7, 4, 0);

    // Reset in the middle of an op.
    tick();
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst.busy", 32'(busy), 0);
    check("mrst.done", 32'(done), 0);
    check("mrst.D",    32'(d),    0);
    check("mrst.Bout", 32'(bout), 0);
    check("mrst.V",    32'(v),    0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("mrst.no_done", 32'(seen), 0);
    do_op("post_rst", 5, 2, 0);

    for (int i = 0; i < 30; i++) begin
      int unsigned ra, rb, rbi;
      ra  = $urandom_range(0, (1 << W) - 1);
      rb  = $urandom_range(0, (1 << W) - 1);
      rbi = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) tick();
      do_op("rand", ra, rb, rbi);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
